// File: rtl/colour_seq_pkg.sv
// Shared types and constants for the colour sequence engine.
// The FSM state enum, the default colour type and the LFSR constants live here.
package colour_seq_pkg;

    localparam int          COLOUR_W_DEFAULT  = 2;
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;

    typedef logic [COLOUR_W_DEFAULT-1:0] colour_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GEN      = 3'd1,
        ST_SHOW_ON  = 3'd2,
        ST_SHOW_GAP = 3'd3,
        ST_WAIT_IN  = 3'd4,
        ST_PASS     = 3'd5,
        ST_FAIL     = 3'd6
    } seq_state_t;

    // Larger of two integers, used to size the shared down-counter.
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/colour_seq_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), right-shifting.
// load takes a new seed (zero seed replaced by the default), advance steps once.
// Only the low COLOUR_W bits are exported: they are the next colour.
module seq_lfsr
    import colour_seq_pkg::*;
#(
    parameter int COLOUR_W = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic                advance,
    input  logic [15:0]         seed,
    output logic [COLOUR_W-1:0] colour
);

    logic [15:0] lfsr_q;

    // Seed load has priority over stepping; reset restores the default seed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_DEFAULT_SEED;
        end else if (load) begin
            lfsr_q <= (seed == 16'h0000) ? LFSR_DEFAULT_SEED : seed;
        end else if (advance) begin
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
        end
    end

    assign colour = lfsr_q[COLOUR_W-1:0];

endmodule

// File: rtl/colour_seq_engine.sv
// Colour sequence engine for the memory game: generates a pseudo-random
// colour sequence, plays it back with dwell/gap timing, then checks the
// player's entries in order and pulses pass or fail.
// Optional feature: define SEQ_TIMEOUT_EN to fail a round when the player
// leaves TIMEOUT_CYCLES cycles between entries (timeout pulses with fail).
// Handshake: colour_in_valid is a one-cycle strobe with no ready; it is only
// consumed in WAIT_IN and dropped in every other state. start is likewise
// only consumed in IDLE. pass/fail/timeout are single-cycle pulses.
module colour_seq_engine
    import colour_seq_pkg::*;
#(
    parameter int COLOUR_W       = 2,
    parameter int MAX_LEN        = 16,
    parameter int LEN_W          = 5,
    parameter int DWELL_CYCLES   = 1000,
    parameter int GAP_CYCLES     = 250,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [LEN_W-1:0]    seq_len,
    input  logic [15:0]         seed,
    input  logic                colour_in_valid,
    input  logic [COLOUR_W-1:0] colour_in,
    output logic                show_valid,
    output logic [COLOUR_W-1:0] show_colour,
    output logic                busy,
    output logic                awaiting_input,
    output logic                pass,
    output logic                fail,
    output logic                timeout,
    output logic [LEN_W-1:0]    round_len,
    output logic [2:0]          state_dbg
);

    localparam int IDX_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_MAX = max_int(max_int(DWELL_CYCLES, GAP_CYCLES), TIMEOUT_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    seq_state_t          state_q, state_n;
    logic [IDX_W-1:0]    idx_q, idx_n;
    logic [CNT_W-1:0]    cnt_q, cnt_n;
    logic [LEN_W-1:0]    len_q, len_n;
    logic [LEN_W-1:0]    len_eff;
    logic [COLOUR_W-1:0] mem [MAX_LEN];
    logic [COLOUR_W-1:0] cur_colour;
    logic [COLOUR_W-1:0] lfsr_colour;
    logic                mem_we;
    logic                lfsr_load;
    logic                lfsr_adv;
    logic                last_idx;
`ifdef SEQ_TIMEOUT_EN
    logic                to_q, to_n;
`endif

    seq_lfsr #(.COLOUR_W(COLOUR_W)) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (lfsr_load),
        .advance (lfsr_adv),
        .seed    (seed),
        .colour  (lfsr_colour)
    );

    // Requested length clamped into [1, MAX_LEN].
    assign len_eff = (seq_len == '0)                 ? LEN_W'(1)       :
                     (seq_len > LEN_W'(MAX_LEN))     ? LEN_W'(MAX_LEN) : seq_len;

    assign last_idx   = (LEN_W'(idx_q) == (len_q - LEN_W'(1)));
    assign cur_colour = mem[idx_q];

    // Next-state, index and shared down-counter control.
    always_comb begin
        state_n   = state_q;
        idx_n     = idx_q;
        cnt_n     = cnt_q;
        len_n     = len_q;
        mem_we    = 1'b0;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
`ifdef SEQ_TIMEOUT_EN
        to_n      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_n   = ST_GEN;
                    len_n     = len_eff;
                    idx_n     = '0;
                    lfsr_load = 1'b1;
                end
            end
            ST_GEN: begin
                mem_we   = 1'b1;
                lfsr_adv = 1'b1;
                if (last_idx) begin
                    state_n = ST_SHOW_ON;
                    idx_n   = '0;
                    cnt_n   = CNT_W'(DWELL_CYCLES - 1);
                end else begin
                    idx_n = idx_q + IDX_W'(1);
                end
            end
            ST_SHOW_ON: begin
                if (cnt_q == '0) begin
                    state_n = ST_SHOW_GAP;
                    cnt_n   = CNT_W'(GAP_CYCLES - 1);
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            ST_SHOW_GAP: begin
                if (cnt_q != '0) begin
                    cnt_n = cnt_q - CNT_W'(1);
                end else if (last_idx) begin
                    state_n = ST_WAIT_IN;
                    idx_n   = '0;
                    cnt_n   = CNT_W'(TIMEOUT_CYCLES - 1);
                end else begin
                    state_n = ST_SHOW_ON;
                    idx_n   = idx_q + IDX_W'(1);
                    cnt_n   = CNT_W'(DWELL_CYCLES - 1);
                end
            end
            ST_WAIT_IN: begin
                if (colour_in_valid) begin
                    if (colour_in != cur_colour) begin
                        state_n = ST_FAIL;
                    end else if (last_idx) begin
                        state_n = ST_PASS;
                    end else begin
                        idx_n = idx_q + IDX_W'(1);
                    end
`ifdef SEQ_TIMEOUT_EN
                    cnt_n = CNT_W'(TIMEOUT_CYCLES - 1);
                end else if (cnt_q == '0) begin
                    state_n = ST_FAIL;
                    to_n    = 1'b1;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
`endif
                end
            end
            ST_PASS, ST_FAIL: begin
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State, index, counter and latched round length.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
`ifdef SEQ_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
            cnt_q   <= cnt_n;
            len_q   <= len_n;
`ifdef SEQ_TIMEOUT_EN
            to_q    <= to_n;
`endif
        end
    end

    // Sequence storage, written one entry per GEN cycle and kept across rounds.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx_q] <= lfsr_colour;
        end
    end

    assign show_valid     = (state_q == ST_SHOW_ON);
    assign show_colour    = show_valid ? cur_colour : '0;
    assign busy           = (state_q != ST_IDLE);
    assign awaiting_input = (state_q == ST_WAIT_IN);
    assign pass           = (state_q == ST_PASS);
    assign fail           = (state_q == ST_FAIL);
    assign round_len      = len_q;
    assign state_dbg      = state_q;
`ifdef SEQ_TIMEOUT_EN
    assign timeout        = (state_q == ST_FAIL) && to_q;
`else
    assign timeout        = 1'b0;
`endif

endmodule
